// File: rtl/sync_pulse_pkg.sv
// Shared types and default parameter values for the pulse-synchronizer sender.
package sync_pulse_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    localparam int unsigned DEF_CNT_WIDTH     = 8;
    localparam int unsigned DEF_TIMEOUT_WIDTH = 16;
    localparam int unsigned DEF_TIMEOUT       = 0;

endpackage

// File: rtl/sat_updown_cnt.sv
// Saturating up/down event counter with a sticky overflow flag for dropped increments.
module sat_updown_cnt
    import sync_pulse_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_CNT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             ovf
);

    logic full;
    logic drop;

    assign full = &count;
    // A simultaneous inc/dec nets to zero, so it never counts as a drop.
    assign drop = inc && !dec && full;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            case ({inc, dec})
                2'b10: begin
                    if (!full) begin
                        count <= count + WIDTH'(1);
                    end
                end
                2'b01: count <= count - WIDTH'(1);
                default: ;
            endcase

            if (drop) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sync_pulse_sender.sv
// Source-side driver for the toggle pulse synchronizer: queues events and
// issues one sEN per acknowledge round-trip, with overflow/timeout reporting.
module sync_pulse_sender
    import sync_pulse_pkg::*;
#(
    parameter int unsigned CNT_WIDTH     = DEF_CNT_WIDTH,
    parameter int unsigned TIMEOUT_WIDTH = DEF_TIMEOUT_WIDTH,
    parameter int unsigned TIMEOUT       = DEF_TIMEOUT
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 req_en,
    input  logic                 clr_err,
    input  logic                 sRDY,
    output logic                 sEN,
    output logic [CNT_WIDTH-1:0] pending,
    output logic [CNT_WIDTH-1:0] sent,
    output logic                 busy,
    output logic                 ovf_err,
    output logic                 timeout_err
);

    localparam bit          TO_EN     = (TIMEOUT != 0);
    localparam int unsigned TO_LAST_I = TO_EN ? (TIMEOUT - 1) : 0;
    localparam logic [TIMEOUT_WIDTH-1:0] TO_LAST = TIMEOUT_WIDTH'(TO_LAST_I);

    state_t                   state;
    logic [TIMEOUT_WIDTH-1:0] wait_cnt;
    logic                     fire;
    logic                     timeout_hit;

    // sRDY comes straight from a synchronizer flop, so this path is loop-free.
    assign fire        = (state == IDLE) && sRDY && (|pending);
    assign sEN         = fire;
    assign busy        = (|pending) || (state == WAIT_ACK);
    assign timeout_hit = TO_EN && (state == WAIT_ACK) && !sRDY && (wait_cnt == TO_LAST);

    sat_updown_cnt #(
        .WIDTH(CNT_WIDTH)
    ) u_pending (
        .clk    (CLK),
        .rst    (RST),
        .inc    (req_en),
        .dec    (fire),
        .clr_ovf(clr_err),
        .count  (pending),
        .ovf    (ovf_err)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            sent        <= '0;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fire) begin
                        state    <= WAIT_ACK;
                        sent     <= sent + CNT_WIDTH'(1);
                        wait_cnt <= '0;
                    end
                end
                WAIT_ACK: begin
                    if (!(&wait_cnt)) begin
                        wait_cnt <= wait_cnt + TIMEOUT_WIDTH'(1);
                    end
                    if (sRDY) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end else if (clr_err) begin
                timeout_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sync_pulse_sender.sv
// Directed bench: a saturation vector table on a 3-bit instance plus
// hand-written round-trip sequences on an 8-bit instance with TIMEOUT=20.
module tb_sync_pulse_sender;

    logic       CLK;
    logic       RST;

    logic       req, clr, srdy, sen, busy, ovf, tmo;
    logic [7:0] pending, sent;

    logic       req3, clr3, srdy3, sen3, busy3, ovf3, tmo3;
    logic [2:0] pend3, sent3;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    sync_pulse_sender #(
        .CNT_WIDTH    (8),
        .TIMEOUT_WIDTH(16),
        .TIMEOUT      (20)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .req_en     (req),
        .clr_err    (clr),
        .sRDY       (srdy),
        .sEN        (sen),
        .pending    (pending),
        .sent       (sent),
        .busy       (busy),
        .ovf_err    (ovf),
        .timeout_err(tmo)
    );

    sync_pulse_sender #(
        .CNT_WIDTH    (3),
        .TIMEOUT_WIDTH(16),
        .TIMEOUT      (0)
    ) dut3 (
        .CLK        (CLK),
        .RST        (RST),
        .req_en     (req3),
        .clr_err    (clr3),
        .sRDY       (srdy3),
        .sEN        (sen3),
        .pending    (pend3),
        .sent       (sent3),
        .busy       (busy3),
        .ovf_err    (ovf3),
        .timeout_err(tmo3)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Synchronizer source-side model: sRDY drops after sEN for low_len cycles,
    // stays low for 4 cycles after reset, and can be held low with stuck.
    int   low_len = 4;
    logic stuck   = 1'b0;
    int   lowc;

    always @(posedge CLK) begin
        if (RST) begin
            srdy <= 1'b0;
            lowc <= 3;
        end else if (sen) begin
            srdy <= 1'b0;
            lowc <= low_len - 1;
        end else if (!srdy) begin
            if (lowc != 0) lowc <= lowc - 1;
            else if (!stuck) srdy <= 1'b1;
        end
    end

    logic mon_clr = 1'b0;
    int   sen_cnt, min_gap, last_cyc, peak;
    int   cyc  = 0;
    bit   seen = 1'b0;

    always @(posedge CLK) begin
        if (mon_clr) begin
            sen_cnt = 0;
            min_gap = 1 << 30;
            seen    = 1'b0;
            peak    = 0;
        end else begin
            if (sen) begin
                if (seen && (cyc - last_cyc) < min_gap) min_gap = cyc - last_cyc;
                last_cyc = cyc;
                seen     = 1'b1;
                sen_cnt++;
            end
            if (int'(pending) > peak) peak = int'(pending);
        end
        cyc++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic mon_clear();
        @(negedge CLK);
        mon_clr = 1'b1;
        @(negedge CLK);
        mon_clr = 1'b0;
    endtask

    task automatic wait_idle(input int maxc, input string nm);
        int k = 0;
        #1;
        while (busy && k < maxc) begin
            @(negedge CLK);
            #1;
            k++;
        end
        chk(nm, 32'(busy), 0);
    endtask

    typedef struct {
        logic        rdy, rq, cl, sen;
        int unsigned pend, sent;
        logic        ovf, busy;
    } vec_t;

    vec_t tbl[19];

    initial begin
        // rdy, req, clr | sEN before edge | pending, sent, ovf, busy after edge
        for (int i = 0; i < 7; i++) tbl[i] = '{1'b0, 1'b1, 1'b0, 1'b0, i + 1, 0, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 7, 0, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 7, 0, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 7, 0, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 7, 1, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 7, 1, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 7, 1, 1'b0, 1'b1};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 6, 2, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 7, 2, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 7, 2, 1'b1, 1'b1};
        tbl[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 7, 2, 1'b0, 1'b1};
        tbl[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 7, 2, 1'b1, 1'b1};
        tbl[18] = '{1'b0, 1'b0, 1'b1, 1'b0, 7, 2, 1'b0, 1'b1};

        RST = 1'b1;
        {req, clr, req3, clr3, srdy3} = '0;
        repeat (3) @(negedge CLK);
        #1;
        chk("rst_pending", 32'(pending), 0);
        chk("rst_sent", 32'(sent), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_sen", 32'(sen), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_tmo", 32'(tmo), 0);
        chk("rst_pend3", 32'(pend3), 0);
        RST = 1'b0;

        // Saturation / simultaneous inc+dec / set-vs-clear priority on the 3-bit instance.
        for (int i = 0; i < 19; i++) begin
            @(negedge CLK);
            srdy3 = tbl[i].rdy;
            req3  = tbl[i].rq;
            clr3  = tbl[i].cl;
            #1;
            chk($sformatf("tbl%0d_sen", i), 32'(sen3), 32'(tbl[i].sen));
            @(posedge CLK);
            #1;
            chk($sformatf("tbl%0d_pending", i), 32'(pend3), tbl[i].pend);
            chk($sformatf("tbl%0d_sent", i), 32'(sent3), tbl[i].sent);
            chk($sformatf("tbl%0d_ovf", i), 32'(ovf3), 32'(tbl[i].ovf));
            chk($sformatf("tbl%0d_busy", i), 32'(busy3), 32'(tbl[i].busy));
            chk($sformatf("tbl%0d_tmo", i), 32'(tmo3), 0);
        end
        @(negedge CLK);
        {req3, clr3, srdy3} = '0;

        // Single event: sEN one cycle after req_en, WAIT_ACK spans 5 cycles.
        repeat (6) @(negedge CLK);
        low_len = 4;
        mon_clear();
        @(negedge CLK);
        req = 1'b1;
        #1;
        chk("single_sen_early", 32'(sen), 0);
        @(negedge CLK);
        req = 1'b0;
        #1;
        chk("single_sen", 32'(sen), 1);
        chk("single_pending", 32'(pending), 1);
        repeat (5) @(negedge CLK);
        #1;
        chk("single_sent", 32'(sent), 1);
        chk("single_busy_f5", 32'(busy), 1);
        @(negedge CLK);
        #1;
        chk("single_busy_f6", 32'(busy), 0);
        repeat (3) @(negedge CLK);
        chk("single_sen_count", 32'(sen_cnt), 1);

        // Burst of 10 with an 8-cycle low window: pulses 10 cycles apart.
        do_reset();
        repeat (6) @(negedge CLK);
        low_len = 8;
        mon_clear();
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            req = 1'b1;
        end
        @(negedge CLK);
        req = 1'b0;
        wait_idle(300, "burst_idle");
        repeat (2) @(negedge CLK);
        chk("burst_sen_count", 32'(sen_cnt), 10);
        chk("burst_min_gap", 32'(min_gap), 10);
        chk("burst_peak", 32'(peak), 9);
        chk("burst_pending", 32'(pending), 0);
        chk("burst_sent", 32'(sent), 10);
        chk("burst_ovf", 32'(ovf), 0);

        // Timeout: sRDY stuck low after the first sEN.
        do_reset();
        repeat (6) @(negedge CLK);
        low_len = 4;
        stuck   = 1'b1;
        @(negedge CLK);
        req = 1'b1;
        @(negedge CLK);
        #1;
        chk("to_fire", 32'(sen), 1);
        for (int k = 1; k <= 21; k++) begin
            @(negedge CLK);
            req = 1'b0;
            #1;
            if (k == 19) chk("to_tmo_before", 32'(tmo), 0);
            if (k == 21) chk("to_tmo_after", 32'(tmo), 1);
        end
        chk("to_pending_held", 32'(pending), 1);
        stuck = 1'b0;
        begin
            bit found = 1'b0;
            for (int k = 0; k < 20 && !found; k++) begin
                @(negedge CLK);
                #1;
                if (sen) found = 1'b1;
            end
            chk("to_next_fire", 32'(found), 1);
        end
        @(posedge CLK);
        #1;
        chk("to_sent", 32'(sent), 2);
        wait_idle(50, "to_idle");
        chk("to_tmo_sticky", 32'(tmo), 1);
        @(negedge CLK);
        clr = 1'b1;
        @(negedge CLK);
        clr = 1'b0;
        #1;
        chk("to_tmo_clr", 32'(tmo), 0);

        // Reset while in WAIT_ACK with three events queued.
        do_reset();
        repeat (6) @(negedge CLK);
        stuck = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            req = 1'b1;
        end
        @(negedge CLK);
        req = 1'b0;
        #1;
        chk("mid_pending", 32'(pending), 3);
        chk("mid_sent", 32'(sent), 1);
        stuck = 1'b0;
        do_reset();
        #1;
        chk("mid_rst_pending", 32'(pending), 0);
        chk("mid_rst_sent", 32'(sent), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_sen", 32'(sen), 0);
        req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            req = 1'b0;
            #1;
            chk($sformatf("mid_nofire%0d", k), 32'(sen), 0);
        end
        @(negedge CLK);
        #1;
        chk("mid_resume_sen", 32'(sen), 1);
        wait_idle(50, "mid_idle");
        chk("mid_resume_sent", 32'(sent), 1);

        // 256 events with a fast sRDY: sent wraps to 0, no overflow.
        do_reset();
        repeat (6) @(negedge CLK);
        low_len = 1;
        mon_clear();
        for (int i = 0; i < 256; i++) begin
            @(negedge CLK);
            req = 1'b1;
        end
        @(negedge CLK);
        req = 1'b0;
        wait_idle(2000, "wrap_idle");
        repeat (2) @(negedge CLK);
        chk("wrap_sen_count", 32'(sen_cnt), 256);
        chk("wrap_sent", 32'(sent), 0);
        chk("wrap_ovf", 32'(ovf), 0);
        chk("wrap_pending", 32'(pending), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
